// File: rtl/cpu_pkg.sv
// Shared core-wide types and constants for the pipelined MIPS front end.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PC_INC = 4;

  // sll $0,$0,0
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: fetch stage is master, memory is slave.
interface instruction_fetch_if;

  logic                        imem_req;
  logic [cpu_pkg::WORD_W-1:0]  imem_addr;
  logic [cpu_pkg::WORD_W-1:0]  imem_rdata;
  logic                        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Program counter with redirect load, sequential increment and hold; wraps modulo 2^32.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic              increment,
  input  logic [WORD_W-3:0] target,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_next_seq_c
);

  assign pc_next_seq_c = pc + WORD_W'(PC_INC);

  // Redirect targets are word addresses; the low two bits are forced to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (enable) begin
      if (load) begin
        pc <= {target, 2'b00};
      end else if (increment) begin
        pc <= pc_next_seq_c;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues imem reads and loads the IF/ID register,
// buffering one word while decode stalls and flushing to NOP on redirect.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [WORD_W-1:0]   branch_target,
  instruction_fetch_if.master imem,
  output logic [WORD_W-1:0]   instruction,
  output logic [WORD_W-1:0]   pc_plus4,
  output logic                valid
);

  fetch_state_t      state;
  if_id_t            if_id;
  logic [WORD_W-1:0] hold_buf;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_seq;
  logic              redirect;
  logic              fetch_accept;
  logic              hold_release;
  logic              advance;
  logic              unused_target_lsbs;

  assign unused_target_lsbs = ^branch_target[1:0];

  // A redirect outranks everything below enable; stall only matters without one.
  assign redirect     = enable & branch_taken;
  assign fetch_accept = enable & ~branch_taken & (state == FETCH) & imem.imem_ready & ~stall;
  assign hold_release = enable & ~branch_taken & (state == HOLD) & ~stall;
  assign advance      = fetch_accept | hold_release;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .load          (redirect),
    .increment     (advance),
    .target        (branch_target[WORD_W-1:2]),
    .pc            (pc),
    .pc_next_seq_c (pc_seq)
  );

  assign imem.imem_req  = enable & ~reset & (state == FETCH);
  assign imem.imem_addr = pc;

  assign instruction = if_id.instruction;
  assign pc_plus4    = if_id.pc_plus4;
  assign valid       = if_id.valid;

  // FSM, hold buffer and IF/ID register
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      hold_buf <= '0;
      if_id    <= '{instruction: NOP_WORD, pc_plus4: '0, valid: 1'b0};
    end else if (enable) begin
      if (branch_taken) begin
        state    <= FETCH;
        hold_buf <= '0;
        if_id    <= '{instruction: NOP_WORD, pc_plus4: '0, valid: 1'b0};
      end else begin
        case (state)
          FETCH: begin
            if (imem.imem_ready) begin
              if (!stall) begin
                if_id <= '{instruction: imem.imem_rdata, pc_plus4: pc_seq, valid: 1'b1};
              end else begin
                hold_buf <= imem.imem_rdata;
                state    <= HOLD;
              end
            end else if (!stall) begin
              // Memory wait with decode ready: present a bubble.
              if_id.instruction <= NOP_WORD;
              if_id.valid       <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              if_id <= '{instruction: hold_buf, pc_plus4: pc_seq, valid: 1'b1};
              state <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_instruction_fetch;
  import cpu_pkg::*;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        valid;
  logic [31:0] instr_w;
  logic [31:0] pp4_w;
  logic        valid_w;

  instruction_fetch_if bus ();
  instruction_fetch_if bus_w ();

  instruction_fetch u_dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .instruction   (instruction),
    .pc_plus4      (pc_plus4),
    .valid         (valid)
  );

  instruction_fetch #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut_wrap (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus_w),
    .instruction   (instr_w),
    .pc_plus4      (pp4_w),
    .valid         (valid_w)
  );

  // Zero-wait memory returning the address as data for the wrap-around instance
  assign bus_w.imem_ready = 1'b1;
  assign bus_w.imem_rdata = bus_w.imem_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_holding;
  logic [31:0] m_hold;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_valid;

  // Combinational outputs observed before the edge, and their model values
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        exp_req;
  logic [31:0] exp_addr;

  // One clock: apply inputs, sample request side mid-cycle, advance the model at the edge.
  task automatic step(input logic rst, input logic en, input logic st, input logic bt,
                      input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata);
    reset = rst; enable = en; stall = st; branch_taken = bt; branch_target = tgt;
    bus.imem_ready = rdy; bus.imem_rdata = rdata;
    @(negedge clock);
    obs_req  = bus.imem_req;
    obs_addr = bus.imem_addr;
    exp_req  = en & ~rst & ~m_holding;
    exp_addr = m_pc;
    @(posedge clock);
    if (rst) begin
      m_pc = 32'h0; m_holding = 1'b0; m_hold = 32'h0;
      m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (en) begin
      if (bt) begin
        m_pc = {tgt[31:2], 2'b00}; m_holding = 1'b0;
        m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (m_holding) begin
        if (!st) begin
          m_instr = m_hold; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
          m_pc = m_pc + 32'd4; m_holding = 1'b0;
        end
      end else if (rdy) begin
        if (!st) begin
          m_instr = rdata; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end else begin
          m_hold = rdata; m_holding = 1'b1;
        end
      end else if (!st) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    n_cmp++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", obs_req); end
    n_cmp++; if (instruction !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", instruction, NOP); end
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_pp4: got %h want 0", pc_plus4); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 32'h0, 1, 32'(4 * i));
      n_cmp++; if ({obs_req, obs_addr} !== {1'b1, 32'(4 * i)}) begin
        n_err++; $display("FAIL seq_req_addr[%0d]: got %b/%h want 1/%h", i, obs_req, obs_addr, 32'(4 * i)); end
      n_cmp++; if ({instruction, pc_plus4, valid} !== {32'(4 * i), 32'(4 * i + 4), 1'b1}) begin
        n_err++; $display("FAIL seq_ifid[%0d]: got %h/%h/%b want %h/%h/1", i, instruction, pc_plus4, valid,
                          32'(4 * i), 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 32'h0, 0, $urandom());
      n_cmp++; if ({valid, instruction, obs_addr} !== {1'b0, NOP, 32'h10}) begin
        n_err++; $display("FAIL wait_bubble[%0d]: got %b/%h/%h want 0/%h/00000010", i, valid, instruction, obs_addr, NOP); end
    end
    step(0, 1, 0, 0, 32'h0, 1, 32'h10);
    n_cmp++; if ({instruction, pc_plus4, valid} !== {32'h10, 32'h14, 1'b1}) begin
      n_err++; $display("FAIL wait_deliver: got %h/%h/%b want 00000010/00000014/1", instruction, pc_plus4, valid); end
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 1, m_pc);
    step(0, 1, 1, 0, 32'h0, 1, 32'h20);
    n_cmp++; if ({instruction, valid} !== {32'h1C, 1'b1}) begin
      n_err++; $display("FAIL hold_ifid_kept: got %h/%b want 0000001c/1", instruction, valid); end
    step(0, 1, 1, 0, 32'h0, 1'($urandom()), $urandom());
    n_cmp++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", obs_req); end
    step(0, 1, 0, 0, 32'h0, 1'($urandom()), $urandom());
    n_cmp++; if ({instruction, pc_plus4, valid} !== {32'h20, 32'h24, 1'b1}) begin
      n_err++; $display("FAIL hold_release: got %h/%h/%b want 00000020/00000024/1", instruction, pc_plus4, valid); end
    step(0, 1, 0, 0, 32'h0, 1, 32'h24);
    n_cmp++; if ({obs_req, obs_addr} !== {1'b1, 32'h24}) begin
      n_err++; $display("FAIL hold_next_req: got %b/%h want 1/00000024", obs_req, obs_addr); end
  endtask

  task automatic test_branch_in_hold();
    step(0, 1, 1, 0, 32'h0, 1, 32'h28);
    step(0, 1, 1, 1, 32'h103, 1'($urandom()), $urandom());
    n_cmp++; if ({instruction, pc_plus4, valid} !== {NOP, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL branch_flush: got %h/%h/%b want %h/00000000/0", instruction, pc_plus4, valid, NOP); end
    step(0, 1, 0, 0, 32'h0, 1, 32'h100);
    n_cmp++; if ({obs_req, obs_addr} !== {1'b1, 32'h100}) begin
      n_err++; $display("FAIL branch_addr: got %b/%h want 1/00000100", obs_req, obs_addr); end
    n_cmp++; if ({instruction, pc_plus4, valid} !== {32'h100, 32'h104, 1'b1}) begin
      n_err++; $display("FAIL branch_target_word: got %h/%h/%b want 00000100/00000104/1", instruction, pc_plus4, valid); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_i [3];
    logic [31:0] exp_p [3];
    exp_i = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_p = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    step(1, 1, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 32'h0, 1, m_pc);
      n_cmp++; if ({instr_w, pp4_w, valid_w} !== {exp_i[i], exp_p[i], 1'b1}) begin
        n_err++; $display("FAIL wrap[%0d]: got %h/%h/%b want %h/%h/1", i, instr_w, pp4_w, valid_w, exp_i[i], exp_p[i]); end
    end
    n_cmp++; if (bus_w.imem_addr !== 32'h4) begin
      n_err++; $display("FAIL wrap_addr: got %h want 00000004", bus_w.imem_addr); end
  endtask

  // Runs right after test_pc_wrap, so the main instance has fetched 0,4,8 and pc=0xC.
  task automatic test_enable_and_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1'($urandom()), 1'($urandom()), $urandom(), 1'($urandom()), $urandom());
      n_cmp++; if ({obs_req, obs_addr} !== {1'b0, 32'hC}) begin
        n_err++; $display("FAIL dis_req[%0d]: got %b/%h want 0/0000000c", i, obs_req, obs_addr); end
      n_cmp++; if ({instruction, pc_plus4, valid} !== {32'h8, 32'hC, 1'b1}) begin
        n_err++; $display("FAIL dis_frozen[%0d]: got %h/%h/%b want 00000008/0000000c/1", i, instruction, pc_plus4, valid); end
    end
    step(0, 1, 0, 0, 32'h0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0, 1, 32'hBAD0_BAD0);
    n_cmp++; if ({instruction, pc_plus4, valid} !== {NOP, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL rst_wait: got %h/%h/%b want %h/00000000/0", instruction, pc_plus4, valid, NOP); end
    step(0, 1, 0, 0, 32'h0, 0, 32'h0);
    n_cmp++; if ({obs_req, obs_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL rst_pc: got %b/%h want 1/00000000", obs_req, obs_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(63) == 0), 1'($urandom_range(7) != 0), 1'($urandom_range(2) == 0),
           1'($urandom_range(7) == 0), $urandom(), 1'($urandom_range(2) != 0), $urandom());
      n_cmp++; if ({obs_req, obs_addr, instruction, pc_plus4, valid} !==
                   {exp_req, exp_addr, m_instr, m_pp4, m_valid}) begin
        n_err++; $display("FAIL random[%0d]: got req=%b addr=%h ifid=%h/%h/%b want req=%b addr=%h ifid=%h/%h/%b",
                          i, obs_req, obs_addr, instruction, pc_plus4, valid,
                          exp_req, exp_addr, m_instr, m_pp4, m_valid); end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    @(posedge clock); #1;
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_hold();
    test_branch_in_hold();
    test_pc_wrap();
    test_enable_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage of the pipelined MIPS core: owns the program counter, drives the instruction-memory request, and loads the IF/ID pipeline register whose `instruction` output feeds instruction_decode. It honours decode-side stalls via a one-word hold buffer, redirects on taken branches/jumps, and flushes the fetched word to a NOP when redirected.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_WORD, 32'h0000_0000: instruction emitted on flush or bubble (sll $0,$0,0).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  global run enable; low freezes all state.
- stall  in  1  decode cannot accept a new instruction this cycle.
- branch_taken  in  1  redirect request from later stage.
- branch_target  in  32  redirect PC; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned read address (= pc).
- imem_rdata  in  32  read data, valid when imem_ready is high.
- imem_ready  in  1  read completes this cycle; may be high in the same cycle as the request (zero wait).
- instruction  out  32  IF/ID instruction register.
- pc_plus4  out  32  IF/ID copy of fetch PC + 4.
- valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- States: FETCH (request outstanding), HOLD (word captured, decode stalled).
- imem_req = enable & !reset & (state == FETCH). imem_addr = pc at all times.
- FETCH, imem_ready=1, branch_taken=0, stall=0: IF/ID <= {imem_rdata, pc+4, 1}; pc <= pc+4; stay FETCH.
- FETCH, imem_ready=1, branch_taken=0, stall=1: hold_buf <= imem_rdata; IF/ID unchanged; go HOLD.
- FETCH, imem_ready=0, branch_taken=0: pc unchanged. If stall=0, valid <= 0 and instruction <= NOP_WORD (bubble). If stall=1, IF/ID unchanged.
- HOLD: imem_req=0. On stall=0: IF/ID <= {hold_buf, pc+4, 1}; pc <= pc+4; go FETCH. On stall=1: stay HOLD.
- branch_taken=1 (any state, enable=1): pc <= {branch_target[31:2],2'b00}; IF/ID <= {NOP_WORD, 0, 0} regardless of stall; any returning imem_rdata and hold_buf are discarded; next state FETCH. The memory accepts an address change while imem_req stays high.
- Priority: reset > enable=0 > branch_taken > stall > normal fetch.
- enable=0: pc, state, hold_buf and IF/ID hold; imem_req=0; imem_ready ignored.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, and pc_plus4 wraps the same way.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, instruction=NOP_WORD, pc_plus4=0, valid=0, hold_buf=0. imem_req=0 while reset is high, and 1 in the first cycle after release (if enable=1).
- Fetch latency: word returned with imem_ready at edge N is visible on instruction/valid after edge N. With zero-wait memory this is 1 cycle from request.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall.
- Redirect penalty: branch_taken at edge N produces valid=0 after N. The target word is valid after edge N+1 at the earliest.
- Stall release from HOLD: buffered word appears 1 cycle after stall falls. The next request issues in the same cycle, so there is no lost slot beyond that.
- Reset mid-wait: an outstanding request is abandoned, and any imem_ready in the reset cycle is ignored.

## Structure
- Shared package cpu_pkg: WORD_W=32, NOP constant, fetch_state_t enum {FETCH, HOLD}, PC_INC=4.
- One natural sub-module: pc_register. It holds pc with load/increment/hold controls, RESET_PC, and wrap-around. The IF/ID register, hold buffer and FSM stay in instruction_fetch.

## Test plan
- Reset then run with zero-wait memory returning addr as data. Required: instruction = 0,4,8,C on consecutive cycles, and pc_plus4 = 4,8,C,10.
- imem_ready held low for 3 cycles at pc=0x10 with stall=0. Required: valid=0 and NOP for 3 cycles, imem_addr stays 0x10, and then 0x10 is delivered with pc_plus4=0x14.
- Word 0x20 returned while stall=1 for 2 cycles. Required: HOLD entered with imem_req=0; on release instruction=0x20 and valid=1, and the next request is at 0x24.
- branch_taken with branch_target=0x103 during HOLD with stall=1. Required: valid=0 next cycle, hold_buf discarded, imem_addr=0x100, and then 0x100 is fetched.
- RESET_PC=32'hFFFF_FFF8 with sequential fetches. Required: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, and pc_plus4 wraps to 0.
- enable=0 for 2 cycles mid-stream, then reset asserted during an imem wait. Required: all outputs frozen and imem_req=0 while disabled; after reset, pc=RESET_PC, valid=0 and instruction=NOP.
